// File: rtl/seg_display_scan.sv
// Multiplexed 7-segment scanner: NUM_DIGITS hex digits on a shared active-low
// cathode bus, frame-synchronous input capture, blanking, LZ suppression and PWM dimming.
module seg_display_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 100000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_blank,
    input  logic [3:0]              bright,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              pwm_q, pwm_d;
    logic                    init_q, init_d;
    logic                    load_q, load_d;
    logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
    logic                    sh_lz_q, sh_lz_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              cathode_q, cathode_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_start_q, frame_start_d;

    logic                    cnt_last, idx_last, load, lit;
    logic                    lz_run;
    logic [NUM_DIGITS-1:0]   dark;
    logic [3:0]              cur_digit;
    logic                    cur_dp, cur_dark;

    function automatic logic [6:0] seg_pattern(input logic [3:0] v);
        case (v)
            4'h0: seg_pattern = 7'h3F;
            4'h1: seg_pattern = 7'h06;
            4'h2: seg_pattern = 7'h5B;
            4'h3: seg_pattern = 7'h4F;
            4'h4: seg_pattern = 7'h66;
            4'h5: seg_pattern = 7'h6D;
            4'h6: seg_pattern = 7'h7D;
            4'h7: seg_pattern = 7'h07;
            4'h8: seg_pattern = 7'h7F;
            4'h9: seg_pattern = 7'h6F;
            4'hA: seg_pattern = 7'h77;
            4'hB: seg_pattern = 7'h7C;
            4'hC: seg_pattern = 7'h39;
            4'hD: seg_pattern = 7'h5E;
            4'hE: seg_pattern = 7'h79;
            default: seg_pattern = 7'h71;
        endcase
    endfunction

    always_comb begin
        cnt_last = (cnt_q == CNT_W'(DIV - 1));
        idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
        load     = init_q | (cnt_last & idx_last);

        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pwm_d       = pwm_q;
        init_d      = 1'b0;
        load_d      = load;
        sh_digits_d = sh_digits_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        sh_lz_d     = sh_lz_q;

        // Counters hold during the init load so the first frame starts cleanly at cnt=0, idx=0.
        if (!init_q) begin
            cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
            pwm_d = pwm_q + 4'd1;
            if (cnt_last) begin
                idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
            end
        end

        if (load) begin
            sh_digits_d = digits;
            sh_dp_d     = dp;
            sh_blank_d  = blank;
            sh_lz_d     = lz_blank;
        end

        // Walk from the most significant digit down; lz_run stays set while all seen digits are zero.
        lz_run = 1'b1;
        dark   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run  = lz_run & (sh_digits_q[4*i +: 4] == 4'h0);
            dark[i] = sh_blank_q[i] | (sh_lz_q & (i != 0) & lz_run);
        end

        cur_digit = 4'h0;
        cur_dp    = 1'b0;
        cur_dark  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = sh_digits_q[4*i +: 4];
                cur_dp    = sh_dp_q[i];
                cur_dark  = dark[i];
            end
        end

        lit = !cur_dark && (cnt_q != '0) && (pwm_q <= bright);

        anode_d   = '1;
        cathode_d = 7'h7F;
        dp_n_d    = 1'b1;
        if (lit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) anode_d[i] = 1'b0;
            end
            cathode_d = ~seg_pattern(cur_digit);
            dp_n_d    = ~cur_dp;
        end

        // The cycle after a load is the state (cnt=0, idx=0) of the new frame.
        frame_start_d = load_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            init_q        <= 1'b1;
            load_q        <= 1'b0;
            sh_digits_q   <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            sh_lz_q       <= 1'b0;
            anode_q       <= '1;
            cathode_q     <= 7'h7F;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            init_q        <= init_d;
            load_q        <= load_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_lz_q       <= sh_lz_d;
            anode_q       <= anode_d;
            cathode_q     <= cathode_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anode       = anode_q;
    assign cathode     = cathode_q;
    assign dp_n        = dp_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Bench for seg_display_scan (4 digits, 8-cycle slots): per-frame expected output
// words go into a queue, a negedge monitor pops and compares one word per cycle.
module tb_seg_display_scan;

    localparam int ND = 4;
    localparam int DV = 8;

    logic          clock;
    logic          reset_n;
    logic [15:0]   digits;
    logic [3:0]    dp;
    logic [3:0]    blank;
    logic          lz_blank;
    logic [3:0]    bright;
    logic [3:0]    anode;
    logic [6:0]    cathode;
    logic          dp_n;
    logic          frame_start;

    // Word layout: {anode[3:0], cathode[6:0], dp_n, frame_start}
    logic [12:0]   exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            edge_n   = -1;
    int            obs_c    = 0;
    logic          mon_en   = 1'b0;

    localparam logic [12:0] IDLE_W = {4'hF, 7'h7F, 1'b1, 1'b0};

    localparam logic [27:0] CATH_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] CATH_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] CATH_0050 = {7'h7F, 7'h7F, 7'h12, 7'h40};
    localparam logic [27:0] CATH_0000 = {7'h40, 7'h40, 7'h40, 7'h40};

    seg_display_scan #(.NUM_DIGITS(ND), .DIV(DV)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .lz_blank    (lz_blank),
        .bright      (bright),
        .anode       (anode),
        .cathode     (cathode),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Driver tasks
    task automatic goto_edge(input int k);
        while (edge_n < k) begin
            @(posedge clock);
            edge_n++;
        end
        #1;
    endtask

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] dpv,
                              input logic [3:0] bl, input logic lz);
        digits   = d;
        dp       = dpv;
        blank    = bl;
        lz_blank = lz;
    endtask

    // One frame of expected words: slot = c/8, cnt = c%8, pwm = c%16 (frame is a multiple of 16).
    task automatic push_frame(input logic [27:0] cath, input logic [3:0] dark_m,
                              input logic [3:0] dp_m, input int br);
        logic [3:0] an;
        logic [6:0] ca;
        logic       dn;
        logic       lit;
        int         slot, cnt, pwm;
        for (int c = 0; c < ND * DV; c++) begin
            slot = c / DV;
            cnt  = c % DV;
            pwm  = c % 16;
            lit  = !dark_m[slot] && (cnt != 0) && (pwm <= br);
            an   = 4'hF;
            ca   = 7'h7F;
            dn   = 1'b1;
            if (lit) begin
                an[slot] = 1'b0;
                ca       = cath[7*slot +: 7];
                dn       = ~dp_m[slot];
            end
            exp_q.push_back({an, ca, dn, (c == 0)});
        end
    endtask

    task automatic check_idle(input string name);
        logic [12:0] got;
        got = {anode, cathode, dp_n, frame_start};
        n_checks++;
        if (got === IDLE_W) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, IDLE_W);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset_n = 1'b1;
        edge_n  = -1;
        goto_edge(1);
        mon_en  = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        logic [12:0] e;
        logic [12:0] got;
        if (mon_en) begin
            n_checks++;
            got = {anode, cathode, dp_n, frame_start};
            if (exp_q.size() == 0) begin
                $display("FAIL scan_underflow: cycle %0d got %h with no expected word", obs_c, got);
            end else begin
                e = exp_q.pop_front();
                if (got === e) n_pass++;
                else $display("FAIL scan cycle %0d: got an=%h ca=%h dpn=%b fs=%b expected an=%h ca=%h dpn=%b fs=%b",
                              obs_c, got[12:9], got[8:2], got[1], got[0], e[12:9], e[8:2], e[1], e[0]);
            end
            obs_c++;
        end
    end

    initial begin
        int guard;
        reset_n = 1'b0;
        set_inputs(16'h9F3C, 4'b1010, 4'b0101, 1'b1);
        bright = 4'd9;
        repeat (2) @(negedge clock);
        check_idle("reset_hold_arbitrary");

        // Frame 0: basic scan 1234 at full brightness
        set_inputs(16'h1234, 4'b0000, 4'b0000, 1'b0);
        bright = 4'd15;
        push_frame(CATH_1234, 4'b0000, 4'b0000, 15);
        release_reset();

        // Frame 1: same data; digits change mid-frame must not tear
        goto_edge(31);
        set_inputs(16'h1234, 4'b0000, 4'b0000, 1'b0);
        push_frame(CATH_1234, 4'b0000, 4'b0000, 15);
        goto_edge(42);
        digits = 16'hABCD;

        // Frame 2: ABCD picked up at the boundary
        goto_edge(63);
        push_frame(CATH_ABCD, 4'b0000, 4'b0000, 15);

        // Frame 3: leading-zero suppression of 0050
        goto_edge(95);
        set_inputs(16'h0050, 4'b0000, 4'b0000, 1'b1);
        push_frame(CATH_0050, 4'b1100, 4'b0000, 15);

        // Frame 4: all zeros, only digit 0 lit
        goto_edge(127);
        set_inputs(16'h0000, 4'b0000, 4'b0000, 1'b1);
        push_frame(CATH_0000, 4'b1110, 4'b0000, 15);

        // Frame 5: blank digit 2, dp on digits 1 and 2
        goto_edge(159);
        set_inputs(16'h1234, 4'b0110, 4'b0100, 1'b0);
        push_frame(CATH_1234, 4'b0100, 4'b0110, 15);

        // Frame 6: brightness 0
        goto_edge(191);
        set_inputs(16'h1234, 4'b0000, 4'b0000, 1'b0);
        push_frame(CATH_1234, 4'b0000, 4'b0000, 0);
        goto_edge(192);
        bright = 4'd0;

        // Frame 7: brightness 7
        goto_edge(223);
        push_frame(CATH_1234, 4'b0000, 4'b0000, 7);
        goto_edge(224);
        bright = 4'd7;

        // Frame 8: reset asserted in the middle of slot 2
        goto_edge(255);
        push_frame(CATH_1234, 4'b0000, 4'b0000, 15);
        goto_edge(256);
        bright = 4'd15;
        goto_edge(256 + 20);
        #1;
        reset_n = 1'b0;
        mon_en  = 1'b0;
        exp_q.delete();
        #1;
        check_idle("reset_mid_slot2");
        repeat (2) begin
            @(negedge clock);
            check_idle("reset_mid_hold");
        end

        // Restart: new frame begins at digit 0 with a frame_start pulse
        set_inputs(16'hABCD, 4'b0000, 4'b0000, 1'b0);
        push_frame(CATH_ABCD, 4'b0000, 4'b0000, 15);
        release_reset();

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clock);
            guard++;
        end
        mon_en = 1'b0;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d words left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Parametrised multiplexed 7-segment display driver: scans `NUM_DIGITS` hex digits onto a shared active-low cathode bus with one active-low anode per digit. It sits between the recorder's status/counter logic and the board display pins. It generalises the fixed two-digit scanner with configurable digit count and scan rate, and adds:

- frame-synchronous input capture (no tearing)
- per-digit blanking and decimal points
- leading-zero suppression
- 16-level PWM brightness with an anti-ghosting dead cycle

## Interface
- `NUM_DIGITS`, 8 — digits scanned, legal 2..8.
- `DIV`, 100000 — clock cycles per digit slot, legal ≥ 4.
- `clock` in 1 — system clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `digits` in 4*NUM_DIGITS — hex value of digit i at [4i+3:4i]; digit 0 rightmost/least significant.
- `dp` in NUM_DIGITS — decimal point request per digit, 1 = lit.
- `blank` in NUM_DIGITS — force digit i dark, 1 = dark.
- `lz_blank` in 1 — enable leading-zero suppression.
- `bright` in 4 — brightness; on-time (bright+1)/16 of each PWM period.
- `anode` out NUM_DIGITS — digit enables, active-low.
- `cathode` out 7 — segments, active-low; bit 0 = a … bit 6 = g.
- `dp_n` out 1 — decimal point segment, active-low.
- `frame_start` out 1 — one-cycle pulse when a new frame begins.

## Operation
- Prescaler `cnt`, 0..DIV-1, increments every clock and wraps to 0.
  - On wrap, slot index `idx` advances.
  - `idx` runs 0..NUM_DIGITS-1, then wraps to 0.
- `pwm`, a 4-bit free-running counter, increments every clock and wraps 15→0.
- Shadow registers hold `digits`, `dp`, `blank` and `lz_blank`. They load in two cases:
  - on the edge where `cnt`=DIV-1 and `idx`=NUM_DIGITS-1;
  - on the first clock edge after reset release (internal init flag, cleared by that load).
  - Input changes at any other time have no effect until the next load.
- All outputs derive only from the shadow registers.
- Digit i is dark if:
  - shadow `blank[i]`=1, or
  - shadow `lz_blank`=1, i≠0, and every shadow digit from NUM_DIGITS-1 down to i equals 0.
- Lit condition for the current digit: digit not dark, `cnt`≠0 (dead cycle), and `pwm` ≤ `bright`.
- When lit: `anode[idx]`=0 and all other anodes are 1. When not lit: all anodes 1, cathode 7'h7F, dp_n 1.
- When lit, `cathode` = ~pattern(shadow digit idx) and `dp_n` = ~shadow `dp[idx]`.
- Patterns (gfedcba hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- A dark digit keeps its time slot (scan period is constant); a dark digit suppresses its dp.

## Timing
- Reset asserted (asynchronous, any time including mid-frame):
  - `cnt`=0, `idx`=0, `pwm`=0, shadows=0, init flag=1;
  - `anode`=all 1, `cathode`=7'h7F, `dp_n`=1, `frame_start`=0 immediately.
- All outputs are registered: each output cycle reflects the (`cnt`, `idx`, `pwm`, shadow) state of the previous cycle, i.e. 1-cycle latency.
- `frame_start`=1 for exactly one cycle, coinciding with the first output cycle of slot 0 (`cnt`=0, `idx`=0) after each shadow load, including the post-reset load.
- Shadow data captured at a frame boundary is used from slot 0 of that frame. A frame never mixes old and new data.
- Frame period = NUM_DIGITS*DIV cycles. Per slot, the anode is low for at most DIV-1 cycles.
- With `bright`=15, the anode is low for all cycles of the slot except the dead cycle.
- `bright` is not shadowed; a change takes effect on the next PWM compare.

## Test plan
All scenarios use NUM_DIGITS=4, DIV=8.

- **Reset:** hold `reset_n`=0 with arbitrary inputs → anode=4'hF, cathode=7'h7F, dp_n=1, frame_start=0. Assert reset mid-slot 2 → same values in the same cycle; after release, frame_start pulses once and the scan restarts at digit 0.
- **Basic scan:** digits=16'h1234, bright=15, blank=0, lz_blank=0 → anode sequence E,D,B,7, each low 7 of 8 cycles with one dead cycle. Cathodes during digits 0..3: 7'h19, 7'h30, 7'h24, 7'h79. frame_start every 32 cycles.
- **Tearing:** change digits from 16'h1234 to 16'hABCD during slot 1 → remainder of the frame still shows 1234. Next frame shows digit 0 = ~7'h5E = 7'h21.
- **Leading zeros:** digits=16'h0050, lz_blank=1 → digits 3 and 2 dark (anode never low). Digit 1 shows cathode 7'h12; digit 0 shows 7'h40.
  - digits=16'h0000 → only digit 0 lit, cathode 7'h40.
- **Blank/dp:** blank=4'b0100, dp=4'b0110 → digit 2 dark with dp_n=1; digit 1 lit with dp_n=0; digits 0 and 3 lit with dp_n=1.
- **Brightness:** bright=0 → over 64 cycles each digit's anode is low exactly in cycles where pwm=0 and cnt≠0. bright=7 → anode low in slot cycles with pwm ≤ 7 only.
